// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control and status bundle for the baud tick generator
interface baud_tick_gen_if #(
  parameter int NB_DIV  = 16,
  parameter int NB_FRAC = 4,
  parameter int NB_SUB  = 4
);
  logic               i_en;
  logic               i_sync;
  logic               i_div_wr;
  logic [NB_DIV-1:0]  i_div;
  logic [NB_FRAC-1:0] i_frac;
  logic               o_tick;
  logic               o_bit_tick;
  logic [NB_DIV:0]    o_counter;
  logic [NB_SUB-1:0]  o_sub_cnt;
  logic               o_pending;

  modport master (
    output i_en, i_sync, i_div_wr, i_div, i_frac,
    input  o_tick, o_bit_tick, o_counter, o_sub_cnt, o_pending
  );

  modport slave (
    input  i_en, i_sync, i_div_wr, i_div, i_frac,
    output o_tick, o_bit_tick, o_counter, o_sub_cnt, o_pending
  );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - UART oversample/bit tick generator with fractional divisor
module baud_tick_gen #(
  parameter int NB_DIV       = 16,
  parameter int NB_FRAC      = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int NB_SUB       = 4,
  parameter int DEFAULT_DIV  = 326,
  parameter int DEFAULT_FRAC = 0
) (
  input logic            clk,
  input logic            i_rst_n,
  baud_tick_gen_if.slave bus
);

  logic [NB_DIV:0]    cnt;
  logic [NB_SUB-1:0]  sub;
  logic [NB_FRAC-1:0] acc;
  logic               stretch;
  logic [NB_DIV-1:0]  div_act;
  logic [NB_DIV-1:0]  div_sh;
  logic [NB_FRAC-1:0] frac_act;
  logic [NB_FRAC-1:0] frac_sh;
  logic               pend;

  logic [NB_DIV:0]    term;
  logic [NB_FRAC:0]   acc_sum;
  logic               tick;
  logic               apply;

  assign term    = {1'b0, div_act} + {{NB_DIV{1'b0}}, stretch};
  assign acc_sum = {1'b0, acc} + {1'b0, frac_act};
  assign tick    = bus.i_en & ~bus.i_sync & (cnt == term);
  // A pending divisor only lands where the current period cannot be corrupted.
  assign apply   = pend & (tick | ~bus.i_en | bus.i_sync);

  assign bus.o_tick     = tick;
  assign bus.o_bit_tick = tick & (sub == NB_SUB'(OVERSAMPLE - 1));
  assign bus.o_counter  = cnt;
  assign bus.o_sub_cnt  = sub;
  assign bus.o_pending  = pend;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      sub     <= '0;
      acc     <= '0;
      stretch <= 1'b0;
    end else if (bus.i_sync) begin
      cnt     <= '0;
      sub     <= '0;
      acc     <= '0;
      stretch <= 1'b0;
    end else if (bus.i_en) begin
      if (tick) begin
        cnt     <= '0;
        sub     <= sub + 1'b1;
        acc     <= acc_sum[NB_FRAC-1:0];
        stretch <= acc_sum[NB_FRAC];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_act  <= NB_DIV'(DEFAULT_DIV);
      frac_act <= NB_FRAC'(DEFAULT_FRAC);
      div_sh   <= NB_DIV'(DEFAULT_DIV);
      frac_sh  <= NB_FRAC'(DEFAULT_FRAC);
      pend     <= 1'b0;
    end else begin
      if (apply) begin
        div_act  <= div_sh;
        frac_act <= frac_sh;
      end
      // A write coinciding with an apply stays pending for the next event.
      if (bus.i_div_wr) begin
        div_sh  <= bus.i_div;
        frac_sh <= bus.i_frac;
        pend    <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - self-checking bench for baud_tick_gen
module tb_baud_tick_gen;
  localparam int NB_DIV   = 16;
  localparam int NB_FRAC  = 4;
  localparam int OVS      = 16;
  localparam int NB_SUB   = 4;
  localparam int DEF_DIV  = 326;
  localparam int FRAC_MOD = 1 << NB_FRAC;
  localparam int CNT_MOD  = 1 << (NB_DIV + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  baud_tick_gen_if #(.NB_DIV(NB_DIV), .NB_FRAC(NB_FRAC), .NB_SUB(NB_SUB)) bif ();

  baud_tick_gen #(
    .NB_DIV(NB_DIV), .NB_FRAC(NB_FRAC), .OVERSAMPLE(OVS), .NB_SUB(NB_SUB),
    .DEFAULT_DIV(DEF_DIV), .DEFAULT_FRAC(0)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .bus(bif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: position inside the current period, period length = div+1+extra.
  int m_pos, m_ticks, m_acc, m_extra, m_div, m_frac, m_sdiv, m_sfrac;
  bit m_pend;
  int tick_cyc[$];
  int bit_cyc[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int tq(input int i);
    return (i < tick_cyc.size()) ? tick_cyc[i] : -1;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_ticks = 0; m_acc = 0; m_extra = 0;
    m_div = DEF_DIV; m_sdiv = DEF_DIV; m_frac = 0; m_sfrac = 0; m_pend = 1'b0;
  endtask

  task automatic step(input bit en, input bit sync, input bit wr, input int div, input int frac);
    bit e_tick, apply;
    int s;
    bif.i_en = en; bif.i_sync = sync; bif.i_div_wr = wr;
    bif.i_div = NB_DIV'(div); bif.i_frac = NB_FRAC'(frac);
    cyc++;
    #1;
    e_tick = en && !sync && (m_pos == m_div + m_extra);
    check("tick", bif.o_tick, e_tick);
    check("bit_tick", bif.o_bit_tick, e_tick && (m_ticks % OVS == OVS - 1));
    check("counter", bif.o_counter, m_pos);
    check("sub_cnt", bif.o_sub_cnt, m_ticks % OVS);
    check("pending", bif.o_pending, m_pend);
    if (bif.o_tick) tick_cyc.push_back(cyc);
    if (bif.o_bit_tick) bit_cyc.push_back(cyc);
    apply = m_pend && (e_tick || !en || sync);
    if (sync) begin
      m_pos = 0; m_ticks = 0; m_acc = 0; m_extra = 0;
    end else if (en) begin
      if (e_tick) begin
        m_pos = 0;
        m_ticks++;
        s = m_acc + m_frac;
        m_extra = s / FRAC_MOD;
        m_acc = s % FRAC_MOD;
      end else begin
        m_pos = (m_pos + 1) % CNT_MOD;
      end
    end
    if (apply) begin m_div = m_sdiv; m_frac = m_sfrac; m_pend = 1'b0; end
    if (wr) begin m_sdiv = div; m_sfrac = frac; m_pend = 1'b1; end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int p, input string tag);
    for (int k = 0; k < 2000 && m_pos != p; k++) step(1, 0, 0, 0, 0);
    check(tag, bif.o_counter, p);
  endtask

  task automatic run_ticks(input int n, input int limit, input string tag);
    for (int k = 0; k < limit && tick_cyc.size() < n; k++) step(1, 0, 0, 0, 0);
    check(tag, tick_cyc.size(), n);
  endtask

  task automatic wait_applied(input string tag);
    for (int k = 0; k < 2000 && m_pend; k++) step(1, 0, 0, 0, 0);
    check(tag, bif.o_pending, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_iv[5];
    int mark, nt;
    bit en, sync, wr;
    exp_iv = '{5, 5, 6, 5, 6};
    bif.i_en = 1'b0; bif.i_sync = 1'b0; bif.i_div_wr = 1'b0; bif.i_div = '0; bif.i_frac = '0;
    #2;
    check("rst_tick", bif.o_tick, 0);
    check("rst_bit_tick", bif.o_bit_tick, 0);
    check("rst_counter", bif.o_counter, 0);
    check("rst_sub_cnt", bif.o_sub_cnt, 0);
    check("rst_pending", bif.o_pending, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Default timing straight out of reset
    repeat (5240) step(1, 0, 0, 0, 0);
    check("first_tick_cycle", tq(0), 327);
    check("tick_interval", tq(1) - tq(0), 327);
    check("first_bit_tick_cycle", (bit_cyc.size() > 0) ? bit_cyc[0] : -1, 5232);

    // Fractional divisor 4 + 8/16
    run_to(100, "reach_100_frac");
    step(1, 0, 1, 4, 8);
    check("frac_pend_set", bif.o_pending, 1);
    tick_cyc.delete();
    run_ticks(6, 2000, "frac_ticks");
    for (int i = 0; i < 5; i++) check("frac_period", tq(i + 1) - tq(i), exp_iv[i]);

    // Enable hold with an apply during the hold
    step(1, 0, 1, 400, 0);
    wait_applied("apply_400");
    run_to(100, "reach_100_hold");
    nt = tick_cyc.size();
    step(0, 0, 1, 450, 0);
    repeat (9) step(0, 0, 0, 0, 0);
    check("hold_counter", bif.o_counter, 100);
    check("hold_pending", bif.o_pending, 0);
    check("hold_no_ticks", tick_cyc.size(), nt);
    step(1, 0, 0, 0, 0);
    check("resume_counter", bif.o_counter, 101);

    // Phase resync
    run_to(200, "reach_200_sync");
    step(1, 1, 0, 0, 0);
    mark = cyc;
    check("sync_counter", bif.o_counter, 0);
    check("sync_sub", bif.o_sub_cnt, 0);
    tick_cyc.delete();
    run_ticks(1, 1000, "sync_tick");
    check("sync_to_tick", tq(0) - mark, 451);

    // Divisor write on the tick cycle itself
    for (int k = 0; k < 1000 && m_pos != m_div + m_extra; k++) step(1, 0, 0, 0, 0);
    tick_cyc.delete();
    step(1, 0, 1, 9, 0);
    check("wr_on_tick_seen", tick_cyc.size(), 1);
    check("wr_on_tick_pend", bif.o_pending, 1);
    run_ticks(3, 1000, "wr_on_tick_ticks");
    check("wr_on_tick_old_period", tq(1) - tq(0), 451);
    check("wr_on_tick_new_period", tq(2) - tq(1), 10);

    // Asynchronous reset mid-period with a pending write
    step(1, 0, 1, 326, 0);
    wait_applied("apply_326");
    step(1, 0, 1, 50, 0);
    run_to(150, "reach_150_rst");
    check("pre_rst_pending", bif.o_pending, 1);
    rst_n = 1'b0;
    #1;
    check("arst_counter", bif.o_counter, 0);
    check("arst_pending", bif.o_pending, 0);
    check("arst_sub", bif.o_sub_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mark = cyc;
    tick_cyc.delete();
    run_ticks(1, 400, "post_rst_tick");
    check("post_rst_period", tq(0) - mark, 327);

    // Randomised traffic against the reference
    for (int k = 0; k < 20000; k++) begin
      en   = ($urandom_range(7) != 0);
      sync = ($urandom_range(99) == 0);
      wr   = ($urandom_range(29) == 0);
      if (!en && m_pend && m_sdiv < m_pos) en = 1'b1;
      step(en, sync, wr, $urandom_range(12), $urandom_range(15));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
